// File: rtl/ram_dp_clr_if.sv
// Access bus for ram_dp_clr: one write port, one registered read port, and
// the clear/status handshake the core uses to stall while the array is cleared.
interface ram_dp_clr_if #(
  parameter int RAM_WIDTH = 14,
  parameter int ADDR_SIZE = 10
);
  logic                 clr_req;
  logic                 wr_enb;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [RAM_WIDTH-1:0] data_in;
  logic                 rd_enb;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [RAM_WIDTH-1:0] data_out;
  logic                 rd_valid;
  logic                 busy;
  logic                 init_done;
  logic                 addr_err;

  modport master (
    output clr_req, wr_enb, wr_addr, data_in, rd_enb, rd_addr,
    input  data_out, rd_valid, busy, init_done, addr_err
  );

  modport slave (
    input  clr_req, wr_enb, wr_addr, data_in, rd_enb, rd_addr,
    output data_out, rd_valid, busy, init_done, addr_err
  );
endinterface

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with a registered read port and a self-running clear
// engine that fills the array with INIT_VALUE after reset or on request.
module ram_dp_clr #(
  parameter int                   RAM_WIDTH  = 14,
  parameter int                   RAM_DEPTH  = 1024,
  parameter int                   ADDR_SIZE  = 10,
  parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0,
  parameter bit                   RD_BYPASS  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  ram_dp_clr_if.slave bus
);

  localparam int                   IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE + 1)'(RAM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_PTR  = ADDR_SIZE'(RAM_DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ADDR_SIZE-1:0] clr_ptr;
  logic [ADDR_SIZE-1:0] clr_ptr_nxt;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic                 wr_in_range;
  logic                 rd_in_range;
  logic                 wr_hit;
  logic                 rd_accept;
  logic                 err_nxt;
  logic                 mem_we;
  logic [IDX_W-1:0]     mem_widx;
  logic [RAM_WIDTH-1:0] mem_wdata;
  logic [IDX_W-1:0]     rd_idx;
  logic [RAM_WIDTH-1:0] rd_word;

  logic [RAM_WIDTH-1:0] dout_p1;
  logic                 vld_p1;
  logic                 err_p1;

  // Range checks are done one bit wider so RAM_DEPTH == 2**ADDR_SIZE still fits.
  assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_EXT;
  assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_EXT;
  assign wr_hit      = bus.wr_enb & wr_in_range & (bus.wr_addr == bus.rd_addr);
  assign rd_idx      = bus.rd_addr[IDX_W-1:0];

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    err_nxt     = err_p1;
    mem_we      = 1'b0;
    mem_widx    = clr_ptr[IDX_W-1:0];
    mem_wdata   = INIT_VALUE;
    rd_accept   = 1'b0;
    unique case (state)
      CLEAR: begin
        mem_we = 1'b1;
        if (clr_ptr == LAST_PTR) begin
          state_nxt   = READY;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + ADDR_SIZE'(1);
        end
      end
      READY: begin
        mem_we    = bus.wr_enb & wr_in_range;
        mem_widx  = bus.wr_addr[IDX_W-1:0];
        mem_wdata = bus.data_in;
        rd_accept = bus.rd_enb;
        err_nxt   = err_p1 | (bus.wr_enb & ~wr_in_range) | (bus.rd_enb & ~rd_in_range);
        // The access on this edge still completes; the clear then wipes it.
        if (bus.clr_req) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
          err_nxt     = 1'b0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  always_comb begin
    rd_word = mem[rd_idx];
    if (!rd_in_range) begin
      rd_word = '0;
    end else if (RD_BYPASS && wr_hit) begin
      rd_word = bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  // Stage p1: registered read data and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      err_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      dout_p1 <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      err_p1  <= err_nxt;
      vld_p1  <= rd_accept;
      if (rd_accept) begin
        dout_p1 <= rd_word;
      end
    end
  end

  assign bus.data_out  = dout_p1;
  assign bus.rd_valid  = vld_p1;
  assign bus.busy      = (state == CLEAR);
  assign bus.init_done = (state == READY);
  assign bus.addr_err  = err_p1;

endmodule
